rsv_issue_ctrl: RTL and testbench

- Reservation-station issue controller for stable execution pipes. It is the requesting end of the scoreboard request handshake: search_pip, available, req.
- Buffers up to N_ENTRY renamed instructions and tracks source-operand readiness through physical-register wakeups.
- Each cycle it offers the oldest ready entry's pipe to the scoreboard. When the scoreboard grants, it issues that entry to the execution pipe.
- Sits between rename/dispatch and the stable-pipe scoreboard.

---
 rtl/rsv_issue_ctrl_if.sv | 45 ++++
 rtl/rsv_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_rsv_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsv_issue_ctrl_if.sv
// Dispatch, wakeup, scoreboard and issue signals of the reservation-station issue controller.
// Latency: none; this is wiring only.
// Backpressure: alloc_ready throttles dispatch, and scb_available gates issue.
interface rsv_issue_ctrl_if #(
  parameter int PIP_W     = 3,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 32
);
  logic                 flush;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [PIP_W-1:0]     alloc_pipe;
  logic [PREG_W-1:0]    alloc_preg_rd;
  logic [PREG_W-1:0]    alloc_preg_rs1;
  logic                 alloc_rs1_rdy;
  logic [PREG_W-1:0]    alloc_preg_rs2;
  logic                 alloc_rs2_rdy;
  logic [PAYLOAD_W-1:0] alloc_payload;
  logic                 wakeup_valid;
  logic [PREG_W-1:0]    wakeup_preg;
  logic [PIP_W-1:0]     scb_search_pip;
  logic                 scb_available;
  logic                 scb_req;
  logic                 iss_valid;
  logic [PIP_W-1:0]     iss_pipe;
  logic [PREG_W-1:0]    iss_preg_rd;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [2:0]           iss_rsv_id;

  // master: the reservation station itself
  modport master (
    input  flush, alloc_valid, alloc_pipe, alloc_preg_rd, alloc_preg_rs1, alloc_rs1_rdy,
           alloc_preg_rs2, alloc_rs2_rdy, alloc_payload, wakeup_valid, wakeup_preg, scb_available,
    output alloc_ready, scb_search_pip, scb_req, iss_valid, iss_pipe, iss_preg_rd, iss_payload,
           iss_rsv_id
  );

  // slave: dispatch, writeback, scoreboard and execution pipe around it
  modport slave (
    output flush, alloc_valid, alloc_pipe, alloc_preg_rd, alloc_preg_rs1, alloc_rs1_rdy,
           alloc_preg_rs2, alloc_rs2_rdy, alloc_payload, wakeup_valid, wakeup_preg, scb_available,
    input  alloc_ready, scb_search_pip, scb_req, iss_valid, iss_pipe, iss_preg_rd, iss_payload,
           iss_rsv_id
  );
endinterface

// File: rtl/rsv_issue_ctrl.sv
// Reservation-station issue controller: age-ordered compacting queue that offers the oldest ready entry to the scoreboard.
// Latency: issue strobe 1 cycle after scb_req; wakeup-to-grant is 1 cycle (0 cycles with RSV_WAKEUP_BYPASS_EN defined).
// Backpressure: alloc_ready drops while full, and a denied candidate (scb_available=0) blocks all younger entries.
module rsv_issue_ctrl #(
  parameter logic [2:0] RSV_ID    = 3'b0,
  parameter int         N_ENTRY   = 4,
  parameter int         PIP_W     = 3,
  parameter int         PREG_W    = 6,
  parameter int         PAYLOAD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  rsv_issue_ctrl_if.master  bus
);
  localparam int IDX_W = $clog2(N_ENTRY);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic [PIP_W-1:0]     pipe;
    logic [PREG_W-1:0]    preg_rd;
    logic [PREG_W-1:0]    rs1;
    logic                 rs1_rdy;
    logic [PREG_W-1:0]    rs2;
    logic                 rs2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t               ent_q [N_ENTRY];
  entry_t               ent_d [N_ENTRY];
  // One extra always-empty slot so the shift-down can read index i+1 uniformly
  entry_t               woken [N_ENTRY+1];
  entry_t               alloc_ent;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [N_ENTRY-1:0]   ready_vec;
  logic                 cand_found;
  logic [IDX_W-1:0]     cand_idx;
  logic                 issue_fire;
  logic                 alloc_fire;
  logic [CNT_W-1:0]     wr_pos;
  logic                 iss_valid_q;
  logic [PIP_W-1:0]     iss_pipe_q;
  logic [PREG_W-1:0]    iss_preg_rd_q;
  logic [PAYLOAD_W-1:0] iss_payload_q;

  // Per-entry readiness for selection; the bypass lets a same-cycle wakeup count as ready
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
`ifdef RSV_WAKEUP_BYPASS_EN
      ready_vec[i] = ent_q[i].valid
          && (ent_q[i].rs1_rdy || (bus.wakeup_valid && ent_q[i].rs1 == bus.wakeup_preg))
          && (ent_q[i].rs2_rdy || (bus.wakeup_valid && ent_q[i].rs2 == bus.wakeup_preg));
`else
      ready_vec[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
`endif
    end
  end

  // Oldest ready entry wins: scan from the top so the lowest index is written last
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire         = cand_found && bus.scb_available && !bus.flush && !rst;
  assign bus.scb_req        = issue_fire;
  assign bus.scb_search_pip = (cand_found && !rst) ? ent_q[cand_idx].pipe : '0;
  assign bus.alloc_ready    = (count_q != CNT_W'(N_ENTRY));
  assign alloc_fire         = bus.alloc_valid && bus.alloc_ready && !bus.flush;
  // An issue this cycle compacts the queue, so the new entry lands one slot lower
  assign wr_pos             = count_q - CNT_W'(issue_fire);
  assign bus.iss_rsv_id     = RSV_ID;
  assign bus.iss_valid      = iss_valid_q;
  assign bus.iss_pipe       = iss_pipe_q;
  assign bus.iss_preg_rd    = iss_preg_rd_q;
  assign bus.iss_payload    = iss_payload_q;

  // Next queue contents: apply wakeups, remove the issued entry, append the allocation
  always_comb begin
    alloc_ent         = '0;
    alloc_ent.valid   = 1'b1;
    alloc_ent.pipe    = bus.alloc_pipe;
    alloc_ent.preg_rd = bus.alloc_preg_rd;
    alloc_ent.rs1     = bus.alloc_preg_rs1;
    alloc_ent.rs1_rdy = bus.alloc_rs1_rdy
                        || (bus.wakeup_valid && bus.alloc_preg_rs1 == bus.wakeup_preg);
    alloc_ent.rs2     = bus.alloc_preg_rs2;
    alloc_ent.rs2_rdy = bus.alloc_rs2_rdy
                        || (bus.wakeup_valid && bus.alloc_preg_rs2 == bus.wakeup_preg);
    payload_copy: begin
      alloc_ent.payload = bus.alloc_payload;
    end

    woken[N_ENTRY] = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      woken[i] = ent_q[i];
      if (bus.wakeup_valid && ent_q[i].valid) begin
        if (ent_q[i].rs1 == bus.wakeup_preg) woken[i].rs1_rdy = 1'b1;
        if (ent_q[i].rs2 == bus.wakeup_preg) woken[i].rs2_rdy = 1'b1;
      end
    end

    for (int i = 0; i < N_ENTRY; i++) begin
      ent_d[i] = woken[i];
      if (issue_fire && i >= int'(cand_idx)) ent_d[i] = woken[i+1];
      if (alloc_fire && CNT_W'(i) == wr_pos) ent_d[i] = alloc_ent;
      if (bus.flush) ent_d[i] = '0;
    end

    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    if (bus.flush) count_d = '0;
  end

  // Queue state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRY; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  // Issue register: strobe follows the grant, data holds between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q   <= 1'b0;
      iss_pipe_q    <= '0;
      iss_preg_rd_q <= '0;
      iss_payload_q <= '0;
    end else begin
      iss_valid_q <= issue_fire;
      if (issue_fire) begin
        iss_pipe_q    <= ent_q[cand_idx].pipe;
        iss_preg_rd_q <= ent_q[cand_idx].preg_rd;
        iss_payload_q <= ent_q[cand_idx].payload;
      end
    end
  end
endmodule

// File: tb/tb_rsv_issue_ctrl.sv
// Bench for rsv_issue_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared each cycle against a queue-based reference model. Honours RSV_WAKEUP_BYPASS_EN.
module tb_rsv_issue_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsv_issue_ctrl_if #(.PIP_W(3), .PREG_W(6), .PAYLOAD_W(32)) bus ();

  rsv_issue_ctrl #(.RSV_ID(3'b0), .N_ENTRY(N), .PIP_W(3), .PREG_W(6), .PAYLOAD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  pipe;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    bit          r1;
    logic [5:0]  rs2;
    bit          r2;
    logic [31:0] pl;
  } m_ent_t;

  m_ent_t      mq[$];
  logic        e_iss_valid;
  logic [2:0]  e_iss_pipe;
  logic [5:0]  e_iss_rd;
  logic [31:0] e_iss_pl;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the oldest entry the model considers selectable, -1 if none
  function automatic int m_cand();
    bit a, b;
    for (int i = 0; i < mq.size(); i++) begin
      a = mq[i].r1;
      b = mq[i].r2;
`ifdef RSV_WAKEUP_BYPASS_EN
      if (bus.wakeup_valid && bus.wakeup_preg == mq[i].rs1) a = 1;
      if (bus.wakeup_valid && bus.wakeup_preg == mq[i].rs2) b = 1;
`endif
      if (a && b) return i;
    end
    return -1;
  endfunction

  task automatic m_step();
    int     c;
    bit     req, fire_alloc;
    m_ent_t ne;
    if (rst) begin
      mq.delete();
      e_iss_valid = 0; e_iss_pipe = 0; e_iss_rd = 0; e_iss_pl = 0;
    end else begin
      c          = m_cand();
      req        = (c >= 0) && bus.scb_available && !bus.flush;
      fire_alloc = bus.alloc_valid && (mq.size() != N) && !bus.flush;
      ne.pipe = bus.alloc_pipe;   ne.rd = bus.alloc_preg_rd;
      ne.rs1  = bus.alloc_preg_rs1; ne.r1 = bus.alloc_rs1_rdy;
      ne.rs2  = bus.alloc_preg_rs2; ne.r2 = bus.alloc_rs2_rdy;
      ne.pl   = bus.alloc_payload;
      if (bus.wakeup_valid) begin
        if (ne.rs1 == bus.wakeup_preg) ne.r1 = 1;
        if (ne.rs2 == bus.wakeup_preg) ne.r2 = 1;
      end
      if (bus.flush) begin
        mq.delete();
        e_iss_valid = 0;
      end else begin
        e_iss_valid = req;
        if (req) begin
          e_iss_pipe = mq[c].pipe; e_iss_rd = mq[c].rd; e_iss_pl = mq[c].pl;
          mq.delete(c);
        end
        if (bus.wakeup_valid)
          foreach (mq[i]) begin
            if (mq[i].rs1 == bus.wakeup_preg) mq[i].r1 = 1;
            if (mq[i].rs2 == bus.wakeup_preg) mq[i].r2 = 1;
          end
        if (fire_alloc) mq.push_back(ne);
      end
    end
  endtask

  // Reference model advances on every active edge
  initial forever begin
    @(posedge clk);
    m_step();
  end

  // Per-cycle comparison of every output against the model, away from the active edge
  initial forever begin
    int c;
    @(negedge clk);
    #2;
    if (chk_en) begin
      c = m_cand();
      check("alloc_ready", bus.alloc_ready, mq.size() != N);
      check("scb_req", bus.scb_req, !rst && !bus.flush && c >= 0 && bus.scb_available);
      check("scb_search_pip", bus.scb_search_pip, (!rst && c >= 0) ? mq[c].pipe : 3'd0);
      check("iss_valid", bus.iss_valid, e_iss_valid);
      check("iss_pipe", bus.iss_pipe, e_iss_pipe);
      check("iss_preg_rd", bus.iss_preg_rd, e_iss_rd);
      check("iss_payload", bus.iss_payload, e_iss_pl);
      check("iss_rsv_id", bus.iss_rsv_id, 3'd0);
    end
  end

  task automatic idle();
    bus.flush = 0; bus.alloc_valid = 0; bus.alloc_pipe = 0; bus.alloc_preg_rd = 0;
    bus.alloc_preg_rs1 = 0; bus.alloc_rs1_rdy = 0; bus.alloc_preg_rs2 = 0; bus.alloc_rs2_rdy = 0;
    bus.alloc_payload = 0; bus.wakeup_valid = 0; bus.wakeup_preg = 0; bus.scb_available = 0;
  endtask

  task automatic set_alloc(input logic [2:0] p, input logic [5:0] rd, input logic [5:0] s1,
                           input bit r1, input logic [5:0] s2, input bit r2, input logic [31:0] pl);
    bus.alloc_valid = 1; bus.alloc_pipe = p; bus.alloc_preg_rd = rd;
    bus.alloc_preg_rs1 = s1; bus.alloc_rs1_rdy = r1;
    bus.alloc_preg_rs2 = s2; bus.alloc_rs2_rdy = r2; bus.alloc_payload = pl;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    chk_en = 1;
    #1;
    check("reset_iss_valid", bus.iss_valid, 0);
    check("reset_alloc_ready", bus.alloc_ready, 1);
    check("reset_scb_req", bus.scb_req, 0);
    @(negedge clk);
    rst = 0;

    // Single ready entry: offered next cycle, issued the cycle after
    bus.scb_available = 1;
    set_alloc(3'd2, 6'd5, 6'd0, 1, 6'd0, 1, 32'hA5A5_0001);
    @(negedge clk);
    bus.alloc_valid = 0;
    #1;
    check("p1_search_pip", bus.scb_search_pip, 2);
    check("p1_scb_req", bus.scb_req, 1);
    @(negedge clk);
    #1;
    check("p1_iss_valid", bus.iss_valid, 1);
    check("p1_iss_pipe", bus.iss_pipe, 2);
    check("p1_iss_preg_rd", bus.iss_preg_rd, 5);

    // Fill with entries waiting on preg 7, then wake them
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      set_alloc(3'(i + 1), 6'(10 + i), 6'd7, 0, 6'd0, 1, 32'hB000_0000 + 32'(i));
    end
    @(negedge clk);
    bus.alloc_valid = 0;
    #1;
    check("p2_full_alloc_ready", bus.alloc_ready, 0);
    check("p2_blocked_scb_req", bus.scb_req, 0);
    @(negedge clk);
    bus.wakeup_valid = 1; bus.wakeup_preg = 6'd7;
    #1;
`ifdef RSV_WAKEUP_BYPASS_EN
    check("p2_wake_cycle_req", bus.scb_req, 1);
`else
    check("p2_wake_cycle_req", bus.scb_req, 0);
    @(negedge clk);
    bus.wakeup_valid = 0;
    #1;
    check("p2_after_wake_req", bus.scb_req, 1);
    check("p2_after_wake_pip", bus.scb_search_pip, 1);
    @(negedge clk);
    #1;
    check("p2_first_iss_pipe", bus.iss_pipe, 1);
    check("p2_alloc_ready_again", bus.alloc_ready, 1);
`endif
    bus.wakeup_valid = 0;
    repeat (N + 1) @(negedge clk);

    // Denied oldest candidate blocks younger ready entry
    bus.scb_available = 0;
    set_alloc(3'd1, 6'd20, 6'd0, 1, 6'd0, 1, 32'hC000_0001);
    @(negedge clk);
    set_alloc(3'd4, 6'd21, 6'd0, 1, 6'd0, 1, 32'hC000_0002);
    @(negedge clk);
    bus.alloc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("p3_denied_pip", bus.scb_search_pip, 1);
      check("p3_denied_req", bus.scb_req, 0);
      @(negedge clk);
    end
    bus.scb_available = 1;
    #1;
    check("p3_grant_pip", bus.scb_search_pip, 1);
    @(negedge clk);
    #1;
    check("p3_first_iss", bus.iss_pipe, 1);
    check("p3_next_pip", bus.scb_search_pip, 4);
    @(negedge clk);
    #1;
    check("p3_second_iss", bus.iss_pipe, 4);

    // Flush with grantable entries present
    bus.scb_available = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_alloc(3'(i), 6'(30 + i), 6'd0, 1, 6'd0, 1, 32'hD000_0000 + 32'(i));
    end
    @(negedge clk);
    bus.alloc_valid = 0;
    bus.scb_available = 1; bus.flush = 1;
    #1;
    check("p4_flush_req", bus.scb_req, 0);
    @(negedge clk);
    bus.flush = 0;
    #1;
    check("p4_post_iss_valid", bus.iss_valid, 0);
    check("p4_post_alloc_ready", bus.alloc_ready, 1);
    check("p4_post_empty_pip", bus.scb_search_pip, 0);

    // Allocation captures a same-cycle wakeup of rs2
    set_alloc(3'd3, 6'd40, 6'd0, 1, 6'd9, 0, 32'hE000_0009);
    bus.wakeup_valid = 1; bus.wakeup_preg = 6'd9;
    @(negedge clk);
    bus.alloc_valid = 0; bus.wakeup_valid = 0;
    #1;
    check("p5_captured_req", bus.scb_req, 1);
    check("p5_captured_pip", bus.scb_search_pip, 3);
    @(negedge clk);

    // Entry waiting on preg 3, woken later
    set_alloc(3'd5, 6'd41, 6'd3, 0, 6'd0, 1, 32'hF000_0003);
    @(negedge clk);
    bus.alloc_valid = 0;
    #1;
    check("p6_waiting_req", bus.scb_req, 0);
    @(negedge clk);
    bus.wakeup_valid = 1; bus.wakeup_preg = 6'd3;
    #1;
`ifdef RSV_WAKEUP_BYPASS_EN
    check("p6_bypass_req", bus.scb_req, 1);
`else
    check("p6_nobypass_req", bus.scb_req, 0);
`endif
    @(negedge clk);
    bus.wakeup_valid = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.flush         = ($urandom_range(0, 39) == 0);
      bus.alloc_valid   = ($urandom_range(0, 3) != 0);
      bus.alloc_pipe    = 3'($urandom_range(0, 7));
      bus.alloc_preg_rd = 6'($urandom_range(0, 63));
      bus.alloc_preg_rs1 = 6'($urandom_range(0, 7));
      bus.alloc_rs1_rdy = ($urandom_range(0, 2) == 0);
      bus.alloc_preg_rs2 = 6'($urandom_range(0, 7));
      bus.alloc_rs2_rdy = ($urandom_range(0, 2) == 0);
      bus.alloc_payload = $urandom;
      bus.wakeup_valid  = ($urandom_range(0, 1) == 1);
      bus.wakeup_preg   = 6'($urandom_range(0, 7));
      bus.scb_available = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst = 0;
    idle();
    repeat (3) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
